// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU issue controller, the ALU and benches.
// Includes a saturating 16-bit increment used by the optional ALU_ISSUE_STATS_EN counters.
package alu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_ADA = 3'b110;
  localparam logic [2:0] OP_ORA = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    if (en && (val != 16'hFFFF)) begin
      return val + 16'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; full/empty decoded from the MSB compare.
module alu_cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
  assign do_push_s = push_i & (~full_o | pop_i);
  assign do_pop_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered {opcode,x,y} commands to a 16-bit ALU one at a time and returns results on a
// valid/ready port. Define ALU_ISSUE_STATS_EN to add saturating stat_issued/stat_carry counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              alu_en,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_results,
  input  logic              alu_cf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cf,
  output logic [2:0]        res_opcode,
  output logic              busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_carry
`endif
);

  localparam int FW = 3 + 2 * DATA_W;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_INIT = CW'(ALU_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              alu_en_q, alu_en_d;
  logic [2:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_x_q, alu_x_d;
  logic [DATA_W-1:0] alu_y_q, alu_y_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_cf_q, res_cf_d;
  logic [2:0]        res_opcode_q, res_opcode_d;

  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FW-1:0]     fifo_rdata_s;
  logic [2:0]        head_op_s;
  logic [DATA_W-1:0] head_x_s;
  logic [DATA_W-1:0] head_y_s;
  logic              capture_s;

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (in_valid & in_ready),
    .wdata_i ({in_opcode, in_x, in_y}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign head_op_s = fifo_rdata_s[2*DATA_W +: 3];
  assign head_x_s  = fifo_rdata_s[DATA_W +: DATA_W];
  assign head_y_s  = fifo_rdata_s[DATA_W-1:0];
  assign capture_s = (state_q == ST_WAIT) && (cnt_q == CNT_ONE);

  assign in_ready   = ~fifo_full_s;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign alu_en     = alu_en_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_cf     = res_cf_q;
  assign res_opcode = res_opcode_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_en_d     = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_cf_d     = res_cf_q;
    res_opcode_d = res_opcode_q;
    pop_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          // NOP entries are dropped here without touching the ALU-facing registers.
          if (head_op_s != OP_NOP) begin
            alu_opcode_d = head_op_s;
            alu_x_d      = head_x_s;
            alu_y_d      = head_y_s;
            state_d      = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        alu_en_d = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (capture_s) begin
          res_data_d   = alu_results;
          res_cf_d     = alu_cf;
          res_opcode_d = alu_opcode_q;
          res_valid_d  = 1'b1;
          state_d      = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Controller state and every registered output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_en_q     <= 1'b0;
      alu_opcode_q <= 3'b000;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_cf_q     <= 1'b0;
      res_opcode_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_en_q     <= alu_en_d;
      alu_opcode_q <= alu_opcode_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_cf_q     <= res_cf_d;
      res_opcode_q <= res_opcode_d;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_q;
  logic [15:0] stat_carry_q;

  assign stat_issued = stat_issued_q;
  assign stat_carry  = stat_carry_q;

  // Saturating issue and carry-result counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_issued_q <= 16'h0000;
      stat_carry_q  <= 16'h0000;
    end else begin
      stat_issued_q <= sat_inc16(stat_issued_q, state_q == ST_ISSUE);
      stat_carry_q  <= sat_inc16(stat_carry_q, capture_s & alu_cf);
    end
  end
`endif

endmodule
